// File: rtl/pipelined_alu_if.sv
// pipelined_alu_if: operand/result handshake bundle for pipelined_alu.
//   slave  - ALU side: takes in_valid/op/in_a/in_b/out_ready, drives in_ready,
//            out_valid, result and the five status flags.
//   master - producer/consumer side (register-read and writeback stages).
interface pipelined_alu_if #(
    parameter int unsigned WIDTH = 64
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_zero;
    logic             flag_eq;
    logic             flag_neg;
    logic             flag_carry;
    logic             flag_ovf;

    modport slave (
        input  in_valid, op, in_a, in_b, out_ready,
        output in_ready, out_valid, result,
               flag_zero, flag_eq, flag_neg, flag_carry, flag_ovf
    );

    modport master (
        output in_valid, op, in_a, in_b, out_ready,
        input  in_ready, out_valid, result,
               flag_zero, flag_eq, flag_neg, flag_carry, flag_ovf
    );
endinterface

// File: rtl/pipelined_alu.sv
// pipelined_alu: registered, valid/ready handshaked ALU with status flags.
// Single-cycle ops (add/sub/logic/shift/compare) register their result on the
// accept edge; MUL runs an iterative shift-add over WIDTH cycles.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - pipelined_alu_if.slave: in_valid/in_ready/op/in_a/in_b on the issue
//           side, out_valid/out_ready/result/flag_* on the writeback side
module pipelined_alu #(
    parameter int unsigned WIDTH = 64
) (
    input logic            clk,
    input logic            rst_n,
    pipelined_alu_if.slave bus
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam int unsigned CNT_W   = $clog2(WIDTH + 1);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpAnd  = 4'b0010;
    localparam logic [3:0] OpOr   = 4'b0011;
    localparam logic [3:0] OpSll  = 4'b0100;
    localparam logic [3:0] OpSrl  = 4'b0101;
    localparam logic [3:0] OpSra  = 4'b0110;
    localparam logic [3:0] OpXor  = 4'b0111;
    localparam logic [3:0] OpSlt  = 4'b1000;
    localparam logic [3:0] OpSltu = 4'b1001;
    localparam logic [3:0] OpMul  = 4'b1010;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             eq_q, eq_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mul_eq_q, mul_eq_d;

    // Single-cycle datapath
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [SHAMT_W-1:0] shamt;
    logic               slt;
    logic               sltu;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;

    always_comb begin
        sum_ext   = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        diff_ext  = {1'b0, bus.in_a} - {1'b0, bus.in_b};
        shamt     = bus.in_b[SHAMT_W-1:0];
        slt       = $signed(bus.in_a) < $signed(bus.in_b);
        sltu      = bus.in_a < bus.in_b;
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (bus.op)
            OpSub: begin
                alu_res   = diff_ext[WIDTH-1:0];
                // Borrow-out inverted: set when A >= B unsigned.
                alu_carry = ~diff_ext[WIDTH];
                alu_ovf   = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                            (diff_ext[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            OpAnd:  alu_res = bus.in_a & bus.in_b;
            OpOr:   alu_res = bus.in_a | bus.in_b;
            OpXor:  alu_res = bus.in_a ^ bus.in_b;
            OpSll:  alu_res = bus.in_a << shamt;
            OpSrl:  alu_res = bus.in_a >> shamt;
            OpSra:  alu_res = $signed(bus.in_a) >>> shamt;
            OpSlt:  alu_res = {{(WIDTH - 1){1'b0}}, slt};
            OpSltu: begin
                alu_res   = {{(WIDTH - 1){1'b0}}, sltu};
                alu_carry = ~sltu;
            end
            OpMul:  alu_res = '0;
            default: begin
                // ADD and every unassigned opcode
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
        endcase
    end

    // Control and next state
    logic in_ready;
    logic accept;

    always_comb begin
        in_ready = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
        accept   = bus.in_valid && in_ready;

        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        eq_d     = eq_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mul_eq_d = mul_eq_q;

        case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    if (bus.op == OpMul) begin
                        mcand_d  = bus.in_a;
                        mplier_d = bus.in_b;
                        acc_d    = '0;
                        cnt_d    = CNT_W'(WIDTH);
                        mul_eq_d = (bus.in_a == bus.in_b);
                        state_d  = StBusy;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        eq_d     = (bus.in_a == bus.in_b);
                        neg_d    = alu_res[WIDTH-1];
                        carry_d  = alu_carry;
                        ovf_d    = alu_ovf;
                        state_d  = StDone;
                    end
                end else if (state_q == StDone && bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    // Final step: the last partial product is already in acc_d.
                    result_d = acc_d;
                    zero_d   = (acc_d == '0);
                    eq_d     = mul_eq_q;
                    neg_d    = acc_d[WIDTH-1];
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            zero_q   <= 1'b0;
            eq_q     <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            mul_eq_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            eq_q     <= eq_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mul_eq_q <= mul_eq_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_q == StDone);
    assign bus.result     = result_q;
    assign bus.flag_zero  = zero_q;
    assign bus.flag_eq    = eq_q;
    assign bus.flag_neg   = neg_q;
    assign bus.flag_carry = carry_q;
    assign bus.flag_ovf   = ovf_q;
endmodule
